ledtest_wb_master: RTL and testbench

- Wishbone B3 classic single-cycle master, upstream of the 8-bit LED register slave.
- Periodically generates an LED pattern and writes it to the slave's data register at LED_ADR.
- Handles ack/err/rty and a bus timeout.
- Used for board bring-up and as a bus-fabric smoke test without a CPU.

---
 rtl/ledtest_pkg.sv | 27 ++
 rtl/ledtest_pattern_gen.sv | 56 +++++
 rtl/ledtest_wb_master.sv | 212 +++++++++++++++++++++
 tb/tb_ledtest_wb_master.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ledtest_pkg.sv
// Shared encodings for the LED test Wishbone master: pattern modes, FSM states and bus constants.
package ledtest_pkg;

  localparam logic [1:0] MODE_WALK     = 2'b00;
  localparam logic [1:0] MODE_COUNT    = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_TOGGLE   = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Ping-pong direction: left moves toward bit7.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RETRY = 2'd2,
    READ  = 2'd3
  } state_e;

  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/ledtest_pattern_gen.sv
// Next-pattern logic for the LED test master; owns the ping-pong direction,
// which only moves when the master actually consumes a new pattern (advance).
module ledtest_pattern_gen
  import ledtest_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [7:0] cur_pattern,
  input  logic [1:0] mode,
  input  logic       advance,
  output logic [7:0] next_pattern
);

  logic dir_reg;
  logic dir_next;

  always_comb begin
    next_pattern = cur_pattern;
    dir_next     = dir_reg;
    case (mode)
      MODE_WALK: begin
        next_pattern = is_one_hot(cur_pattern) ? {cur_pattern[6:0], cur_pattern[7]} : 8'h01;
      end
      MODE_COUNT: begin
        next_pattern = cur_pattern + 8'h01;
      end
      MODE_PINGPONG: begin
        if (!is_one_hot(cur_pattern)) begin
          next_pattern = 8'h01;
          dir_next     = DIR_LEFT;
        end else begin
          // Bouncing off an end flips direction before the shift.
          if (cur_pattern[7]) begin
            dir_next = DIR_RIGHT;
          end else if (cur_pattern[0]) begin
            dir_next = DIR_LEFT;
          end
          next_pattern = (dir_next == DIR_LEFT) ? {cur_pattern[6:0], 1'b0}
                                                : {1'b0, cur_pattern[7:1]};
        end
      end
      default: begin
        next_pattern = ~cur_pattern;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      dir_reg <= DIR_LEFT;
    end else if (advance) begin
      dir_reg <= dir_next;
    end
  end

endmodule

// File: rtl/ledtest_wb_master.sv
// Wishbone B3 classic master that periodically writes an LED pattern to LED_ADR.
// Define LEDTEST_READBACK_EN to add a read-back/compare cycle after every write.
module ledtest_wb_master
  import ledtest_pkg::*;
#(
  parameter int          TICK_DIV = 25000000,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] LED_ADR  = 32'h0000_0000
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  output logic [31:0] wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  input  logic [7:0]  wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [7:0]  pattern_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  state_e      state_reg, state_next;
  logic        cyc_reg, cyc_next;
  logic        stb_reg, stb_next;
  logic        we_reg, we_next;
  logic [31:0] adr_reg;
  logic [7:0]  dat_reg, dat_next;
  logic [7:0]  pattern_reg, pattern_next;
  logic        err_reg, err_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic        advance;
  logic [7:0]  gen_pattern;

  assign tick = en_i && (cnt_reg == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge wb_clk) begin
    if (wb_rst || !en_i || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  ledtest_pattern_gen u_pattern_gen (
    .clk          (wb_clk),
    .srst         (wb_rst),
    .cur_pattern  (pattern_reg),
    .mode         (mode_i),
    .advance      (advance),
    .next_pattern (gen_pattern)
  );

`ifdef LEDTEST_READBACK_EN
  // Remembers whether a retry gap should resume the read rather than the write.
  logic rd_retry_reg, rd_retry_next;
`else
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i;
`endif

  always_comb begin
    state_next   = state_reg;
    cyc_next     = cyc_reg;
    stb_next     = stb_reg;
    we_next      = we_reg;
    dat_next     = dat_reg;
    pattern_next = pattern_reg;
    err_next     = err_reg;
    tmo_next     = tmo_reg;
    advance      = 1'b0;
`ifdef LEDTEST_READBACK_EN
    rd_retry_next = rd_retry_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (tick) begin
          advance    = 1'b1;
          dat_next   = gen_pattern;
          state_next = WRITE;
          cyc_next   = 1'b1;
          stb_next   = 1'b1;
          we_next    = 1'b1;
          tmo_next   = '0;
        end
      end
      WRITE, READ: begin
        // Every outcome below ends the current bus cycle unless we are still waiting.
        if (wbm_err_i) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b1;
          state_next = IDLE;
        end else if (wbm_ack_i) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          state_next = IDLE;
          if (state_reg == WRITE) begin
            pattern_next = dat_reg;
`ifdef LEDTEST_READBACK_EN
            state_next = READ;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
            tmo_next   = '0;
`endif
          end
`ifdef LEDTEST_READBACK_EN
          else if (wbm_dat_i != dat_reg) begin
            err_next = 1'b1;
          end
`endif
        end else if (wbm_rty_i) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          state_next = RETRY;
`ifdef LEDTEST_READBACK_EN
          rd_retry_next = (state_reg == READ);
`endif
        end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      RETRY: begin
        state_next = WRITE;
        cyc_next   = 1'b1;
        stb_next   = 1'b1;
        we_next    = 1'b1;
        tmo_next   = '0;
`ifdef LEDTEST_READBACK_EN
        if (rd_retry_reg) begin
          state_next = READ;
          we_next    = 1'b0;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        cyc_next   = 1'b0;
        stb_next   = 1'b0;
        we_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg   <= IDLE;
      cyc_reg     <= 1'b0;
      stb_reg     <= 1'b0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      pattern_reg <= '0;
      err_reg     <= 1'b0;
      tmo_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      cyc_reg     <= cyc_next;
      stb_reg     <= stb_next;
      we_reg      <= we_next;
      adr_reg     <= cyc_next ? LED_ADR : '0;
      dat_reg     <= dat_next;
      pattern_reg <= pattern_next;
      err_reg     <= err_next;
      tmo_reg     <= tmo_next;
    end
  end

`ifdef LEDTEST_READBACK_EN
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rd_retry_reg <= 1'b0;
    end else begin
      rd_retry_reg <= rd_retry_next;
    end
  end
`endif

  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = stb_reg;
  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BTE_LINEAR;
  assign pattern_o = pattern_reg;
  assign busy_o    = (state_reg != IDLE);
  assign err_o     = err_reg;

endmodule

// File: tb/tb_ledtest_wb_master.sv
// Randomized bench for ledtest_wb_master against a transaction-level reference model.
// Honours LEDTEST_READBACK_EN when defined for the build.
module tb_ledtest_wb_master;

  localparam int          TICK_DIV = 4;
  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] LED_ADR  = 32'h8000_0040;
  localparam int          N_CYC    = 4000;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  mode;
  logic [31:0] adr;
  logic [7:0]  dat_o, dat_i, pattern;
  logic        we, cyc, stb, ack, err_in, rty, busy, err_flag;
  logic [2:0]  cti;
  logic [1:0]  bte;

  // Slave response knobs, sampled by the DUT only while it strobes.
  logic r_ack, r_err, r_rty, r_bad;
  int   sm;

  int vec_cnt = 0;
  int mis_cnt = 0;
  int cyc_no  = 0;

  always #5 clk = ~clk;

  assign ack    = stb & r_ack;
  assign err_in = stb & r_err;
  assign rty    = stb & r_rty;
  assign dat_i  = dat_o ^ {7'b0, r_bad};

  ledtest_wb_master #(
    .TICK_DIV (TICK_DIV),
    .TIMEOUT  (TIMEOUT),
    .LED_ADR  (LED_ADR)
  ) dut (
    .wb_clk    (clk),
    .wb_rst    (rst),
    .en_i      (en),
    .mode_i    (mode),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_dat_i (dat_i),
    .wbm_we_o  (we),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_cti_o (cti),
    .wbm_bte_o (bte),
    .wbm_ack_i (ack),
    .wbm_err_i (err_in),
    .wbm_rty_i (rty),
    .pattern_o (pattern),
    .busy_o    (busy),
    .err_o     (err_flag)
  );

  // Reference model: phase 0 idle, 1 write, 2 retry gap, 3 read.
  int         ph, ret_ph, m_wait, m_cnt;
  logic [7:0] m_dat, m_pat;
  logic       m_err, m_dir;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic calc_next(input logic [7:0] cur, input logic [1:0] md, output logic [7:0] nxt);
    int pos;
    bit onehot;
    pos = 0;
    for (int i = 0; i < 8; i++) if (cur[i]) pos = i;
    onehot = ($countones(cur) == 1);
    case (md)
      2'd0: nxt = onehot ? 8'(1 << ((pos + 1) % 8)) : 8'h01;
      2'd1: nxt = 8'((int'(cur) + 1) % 256);
      2'd2: begin
        if (!onehot) begin
          m_dir = 1'b0;
          nxt   = 8'h01;
        end else begin
          if (pos == 7) m_dir = 1'b1;
          else if (pos == 0) m_dir = 1'b0;
          nxt = m_dir ? 8'(1 << (pos - 1)) : 8'(1 << (pos + 1));
        end
      end
      default: nxt = 8'(255 - int'(cur));
    endcase
  endtask

  task automatic step_model(input logic rst_in, input logic en_in, input logic [1:0] md,
                            input logic a, input logic e, input logic r, input logic bad);
    bit on_bus, tick;
    logic [7:0] nxt;
    on_bus = (ph == 1) || (ph == 3);
    if (rst_in) begin
      ph = 0; ret_ph = 1; m_wait = 0; m_cnt = 0;
      m_dat = 8'h00; m_pat = 8'h00; m_err = 1'b0; m_dir = 1'b0;
      return;
    end
    tick = 1'b0;
    if (en_in) begin
      m_cnt = (m_cnt + 1) % TICK_DIV;
      tick  = (m_cnt == 0);
    end else begin
      m_cnt = 0;
    end
    case (ph)
      0: if (tick) begin
        calc_next(m_pat, md, nxt);
        m_dat  = nxt;
        ph     = 1;
        m_wait = 0;
      end
      2: begin
        ph     = ret_ph;
        m_wait = 0;
      end
      default: begin
        if (on_bus && e) begin
          m_err = 1'b1;
          ph    = 0;
        end else if (on_bus && a) begin
          if (ph == 1) begin
            m_pat = m_dat;
            $display("cycle %0d: write %02h committed", cyc_no, m_pat);
`ifdef LEDTEST_READBACK_EN
            ph     = 3;
            m_wait = 0;
`else
            ph = 0;
`endif
          end else begin
            if (bad) m_err = 1'b1;
            ph = 0;
          end
        end else if (on_bus && r) begin
          ret_ph = ph;
          ph     = 2;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            m_err = 1'b1;
            ph    = 0;
          end
        end
      end
    endcase
  endtask

  initial begin
    logic       e_cyc;
    logic [9:0] e_ctl;
    rst = 1'b1; en = 1'b0; mode = 2'd0;
    r_ack = 1'b0; r_err = 1'b0; r_rty = 1'b0; r_bad = 1'b0; sm = 1;
    step_model(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ctl", {22'd0, cyc, stb, we, busy, err_flag, cti, bte}, 32'd0);
    check_val("rst_adr", adr, 32'd0);
    check_val("rst_dat", {24'd0, dat_o}, 32'd0);
    check_val("rst_pat", {24'd0, pattern}, 32'd0);

    for (int n = 0; n < N_CYC; n++) begin
      cyc_no = n;
      e_cyc  = (ph == 1) || (ph == 3);
      e_ctl  = {e_cyc, e_cyc, (ph == 1), (ph != 0), m_err, 3'b000, 2'b00};
      check_val("ctl", {22'd0, cyc, stb, we, busy, err_flag, cti, bte}, {22'd0, e_ctl});
      check_val("adr", adr, e_cyc ? LED_ADR : 32'd0);
      check_val("dat", {24'd0, dat_o}, {24'd0, m_dat});
      check_val("pat", {24'd0, pattern}, {24'd0, m_pat});

      if (n % 40 == 0) begin
        if (n < 200) begin
          en = 1'b1; mode = 2'd0; sm = 1; r_bad = 1'b0;
        end else if (n < 400) begin
          en = 1'b1; mode = 2'd2; sm = 1; r_bad = 1'b0;
        end else begin
          en    = ($urandom_range(0, 99) < 85);
          mode  = 2'($urandom_range(0, 3));
          sm    = $urandom_range(0, 99);
          sm    = (sm < 15) ? 0 : (sm < 50) ? 1 : 2;
          r_bad = ($urandom_range(0, 2) == 0);
        end
      end
      rst = (n % 600 == 599);
      case (sm)
        0: begin r_ack = 1'b0; r_err = 1'b0; r_rty = 1'b0; end
        1: begin r_ack = 1'b1; r_err = 1'b0; r_rty = 1'b0; end
        default: begin
          r_ack = ($urandom_range(0, 99) < 50);
          r_err = ($urandom_range(0, 99) < 8);
          r_rty = ($urandom_range(0, 99) < 20);
        end
      endcase
      step_model(rst, en, mode, r_ack, r_err, r_rty, r_bad);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
